// File: rtl/trng_collector.sv
// trng_collector: synchronizes the ring-oscillator TRNG stream, health-checks it and packs it into WIDTH-bit words.
// Optional Von Neumann debiasing is enabled by defining TRNG_VON_NEUMANN_EN.
module trng_collector #(
   parameter int WIDTH         = 32,
   parameter int REP_LIMIT     = 32,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             trng_en,
   input  logic             trng_in,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             error_o,
   input  logic             clear_err_i,
   output logic [2:0]       state_dbg
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARMUP  = 3'd1,
      COLLECT = 3'd2,
      FULL    = 3'd3,
      ERROR   = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [1:0]       sync_q;
   logic             prev_s;
   logic [RW-1:0]    run_cnt, run_next;
   logic [SW-1:0]    settle_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             err_q;
   logic             s, bit_ok, bit_val, run_trip, full_now, keep_word;

   assign s = sync_q[1];

`ifdef TRNG_VON_NEUMANN_EN
   logic vn_have, vn_first;
   // A pair (a,b) with a != b yields a; equal pairs yield nothing.
   assign bit_ok  = (state == COLLECT) && vn_have && (vn_first != s);
   assign bit_val = vn_first;
`else
   assign bit_ok  = (state == COLLECT);
   assign bit_val = s;
`endif

   always_comb begin
      run_next = RW'(1);
      if (run_cnt != '0 && s == prev_s)
         run_next = run_cnt + RW'(1);
   end

   assign run_trip  = (state == COLLECT) && (run_next == RW'(REP_LIMIT));
   assign full_now  = (bit_cnt == BW'(WIDTH));
   assign keep_word = (state_n == FULL) || (state == COLLECT && state_n == COLLECT);

   // Handshake: a word is transferred on a cycle where valid_o && ready_i && enable;
   // data_o holds steady from valid_o rising until that cycle.
   always_comb begin
      state_n = state;
      if (!enable) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    state_n = WARMUP;
            WARMUP:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_n = COLLECT;
            COLLECT: begin
               if (run_trip)      state_n = ERROR;
               else if (full_now) state_n = FULL;
            end
            FULL:    if (ready_i) state_n = COLLECT;
            ERROR:   if (clear_err_i) state_n = WARMUP;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sync_q     <= '0;
         prev_s     <= 1'b0;
         run_cnt    <= '0;
         settle_cnt <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         err_q      <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
         vn_have    <= 1'b0;
         vn_first   <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sync_q     <= {sync_q[0], trng_in};
         prev_s     <= s;
         settle_cnt <= (state == WARMUP && state_n == WARMUP) ? settle_cnt + SW'(1) : '0;
         run_cnt    <= (state == COLLECT && state_n == COLLECT) ? run_next : '0;

         // Any exit other than COLLECT->FULL, including a transfer, drops the word.
         if (!keep_word) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (bit_ok && !full_now) begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= {shreg[WIDTH-2:0], bit_val};
         end

         if (state_n == ERROR)
            err_q <= 1'b1;
         else if (state == ERROR && state_n == WARMUP)
            err_q <= 1'b0;

`ifdef TRNG_VON_NEUMANN_EN
         if (state == COLLECT && state_n == COLLECT) begin
            vn_have <= ~vn_have;
            if (!vn_have) vn_first <= s;
         end else begin
            vn_have <= 1'b0;
         end
`endif
      end
   end

   assign trng_en   = (state != IDLE);
   assign valid_o   = (state == FULL);
   assign data_o    = shreg;
   assign error_o   = err_q;
   assign state_dbg = state;

endmodule
